// File: rtl/ddr_sram_ctrl.sv
// DDR-side request controller: accepts one load, store or 8-beat line read at a time
// and services it against a single-port 64-bit synchronous SRAM after LATENCY wait cycles.
module ddr_sram_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ddr_chip_enable,
  input  logic [ADDR_W-1:0] ddr_index,
  input  logic              ddr_write_enable,
  input  logic              ddr_burst_mode,
  input  logic [63:0]       ddr_opstore_write_mask,
  input  logic [63:0]       ddr_opstore_write_data,
  output logic              ddr_ready,
  output logic              ddr_operation_done,
  output logic [63:0]       ddr_opload_read_data,
  output logic [511:0]      ddr_pc_read_inst,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_wmask,
  output logic [63:0]       sram_wdata,
  input  logic [63:0]       sram_rdata
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
  logic                r_we, w_we_nxt;
  logic                r_burst, w_burst_nxt;
  logic [DATA_W-1:0]   r_mask, w_mask_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_done, w_done_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic                r_sram_ce, w_sram_ce_nxt;
  logic                r_sram_we, w_sram_we_nxt;
  logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nxt;
  logic [DATA_W-1:0]   r_sram_wmask, w_sram_wmask_nxt;
  logic [DATA_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;
  logic                w_go_issue;

  // With LATENCY=0 the first issue is computed in the accept cycle, so take the request from the inputs
  logic                w_in_idle;
  logic [ADDR_W-1:0]   w_req_idx;
  logic                w_req_we;
  logic                w_req_burst;
  logic [DATA_W-1:0]   w_req_mask;
  logic [DATA_W-1:0]   w_req_data;
  logic [BEAT_W-1:0]   w_cap_beat;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_req_idx   = w_in_idle ? ddr_index              : r_idx;
  assign w_req_we    = w_in_idle ? ddr_write_enable       : r_we;
  assign w_req_burst = w_in_idle ? ddr_burst_mode         : r_burst;
  assign w_req_mask  = w_in_idle ? ddr_opstore_write_mask : r_mask;
  assign w_req_data  = w_in_idle ? ddr_opstore_write_data : r_data;
  // Read data trails the issue by one cycle; wraps to beat 7 in CAPTURE once r_beat is back to 0
  assign w_cap_beat  = r_beat - BEAT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_burst      <= 1'b0;
      r_mask       <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_beat       <= '0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_line       <= '0;
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wmask <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_we         <= w_we_nxt;
      r_burst      <= w_burst_nxt;
      r_mask       <= w_mask_nxt;
      r_data       <= w_data_nxt;
      r_cnt        <= w_cnt_nxt;
      r_beat       <= w_beat_nxt;
      r_ready      <= w_ready_nxt;
      r_done       <= w_done_nxt;
      r_rdata      <= w_rdata_nxt;
      r_line       <= w_line_nxt;
      r_sram_ce    <= w_sram_ce_nxt;
      r_sram_we    <= w_sram_we_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wmask <= w_sram_wmask_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_we_nxt         = r_we;
    w_burst_nxt      = r_burst;
    w_mask_nxt       = r_mask;
    w_data_nxt       = r_data;
    w_cnt_nxt        = r_cnt;
    w_beat_nxt       = r_beat;
    w_rdata_nxt      = r_rdata;
    w_line_nxt       = r_line;
    w_sram_ce_nxt    = 1'b0;
    w_sram_we_nxt    = 1'b0;
    w_sram_addr_nxt  = r_sram_addr;
    w_sram_wmask_nxt = r_sram_wmask;
    w_sram_wdata_nxt = r_sram_wdata;
    w_go_issue       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ddr_chip_enable && r_ready) begin
          w_idx_nxt   = ddr_index;
          w_we_nxt    = ddr_write_enable;
          w_burst_nxt = ddr_burst_mode;
          w_mask_nxt  = ddr_opstore_write_mask;
          w_data_nxt  = ddr_opstore_write_data;
          if (LATENCY == 0) begin
            w_go_issue = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_go_issue = 1'b1;
        else             w_cnt_nxt  = r_cnt - CNT_W'(1);
      end
      S_ISSUE: begin
        if (r_burst) begin
          if (r_beat != '0) w_line_nxt[{w_cap_beat, 6'd0} +: DATA_W] = sram_rdata;
          if (r_beat == BEAT_W'(7)) begin
            w_state_nxt = S_CAPTURE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt      = r_beat + BEAT_W'(1);
            w_sram_ce_nxt   = 1'b1;
            w_sram_addr_nxt = r_sram_addr + ADDR_W'(1);
          end
        end else if (r_we) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (r_burst) w_line_nxt[{w_cap_beat, 6'd0} +: DATA_W] = sram_rdata;
        else         w_rdata_nxt = sram_rdata;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // First SRAM access; burst lines start at the aligned base regardless of low index bits
    if (w_go_issue) begin
      w_state_nxt      = S_ISSUE;
      w_beat_nxt       = '0;
      w_sram_ce_nxt    = 1'b1;
      w_sram_we_nxt    = w_req_we & ~w_req_burst;
      w_sram_addr_nxt  = w_req_burst ? {w_req_idx[ADDR_W-1:3], 3'b000} : w_req_idx;
      w_sram_wmask_nxt = w_req_mask;
      w_sram_wdata_nxt = w_req_data;
    end
  end

  assign w_ready_nxt = (w_state_nxt == S_IDLE);
  assign w_done_nxt  = (w_state_nxt == S_DONE);

  assign ddr_ready            = r_ready;
  assign ddr_operation_done   = r_done;
  assign ddr_opload_read_data = r_rdata;
  assign ddr_pc_read_inst     = r_line;
  assign sram_ce              = r_sram_ce;
  assign sram_we              = r_sram_we;
  assign sram_addr            = r_sram_addr;
  assign sram_wmask           = r_sram_wmask;
  assign sram_wdata           = r_sram_wdata;

endmodule

// File: tb/tb_ddr_sram_ctrl.sv
// Scoreboard bench for ddr_sram_ctrl: one instance at LATENCY=4, one at LATENCY=0,
// each backed by a small masked-write SRAM model.
module tb_ddr_sram_ctrl;

  typedef struct {
    int           cyc;
    int           kind;   // 0 write, 1 read, 2 burst
    logic [63:0]  rd;
    logic [511:0] line;
  } exp_t;

  logic         clock;
  logic         rst4, rst0, ce4, ce0;
  logic [18:0]  idx;
  logic         we, bu;
  logic [63:0]  mask, data;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         q4[$];
  exp_t         q0[$];

  logic         rdy4, done4, s4_ce, s4_we;
  logic [63:0]  rd4, s4_mask, s4_wdata, s4_rdata;
  logic [511:0] line4;
  logic [18:0]  s4_addr;
  logic         rdy0, done0, s0_ce, s0_we;
  logic [63:0]  rd0, s0_mask, s0_wdata, s0_rdata;
  logic [511:0] line0;
  logic [18:0]  s0_addr;
  logic [63:0]  mem4 [0:63];
  logic [63:0]  mem0 [0:63];

  ddr_sram_ctrl #(.LATENCY(4), .ADDR_W(19)) u4 (
    .clock(clock), .reset(rst4), .ddr_chip_enable(ce4), .ddr_index(idx),
    .ddr_write_enable(we), .ddr_burst_mode(bu), .ddr_opstore_write_mask(mask),
    .ddr_opstore_write_data(data), .ddr_ready(rdy4), .ddr_operation_done(done4),
    .ddr_opload_read_data(rd4), .ddr_pc_read_inst(line4), .sram_ce(s4_ce),
    .sram_we(s4_we), .sram_addr(s4_addr), .sram_wmask(s4_mask),
    .sram_wdata(s4_wdata), .sram_rdata(s4_rdata));

  ddr_sram_ctrl #(.LATENCY(0), .ADDR_W(19)) u0 (
    .clock(clock), .reset(rst0), .ddr_chip_enable(ce0), .ddr_index(idx),
    .ddr_write_enable(we), .ddr_burst_mode(bu), .ddr_opstore_write_mask(mask),
    .ddr_opstore_write_data(data), .ddr_ready(rdy0), .ddr_operation_done(done0),
    .ddr_opload_read_data(rd0), .ddr_pc_read_inst(line0), .sram_ce(s0_ce),
    .sram_we(s0_we), .sram_addr(s0_addr), .sram_wmask(s0_mask),
    .sram_wdata(s0_wdata), .sram_rdata(s0_rdata));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM models, aliased on the low 6 address bits; refilled while their controller is in reset
  always @(posedge clock) begin
    if (rst4) begin
      for (int i = 0; i < 64; i++) mem4[i] <= 64'(i);
      mem4[32] <= 64'hAAAAAAAA_BBBBBBBB;
    end else if (s4_ce) begin
      if (s4_we) mem4[s4_addr[5:0]] <= (mem4[s4_addr[5:0]] & ~s4_mask) | (s4_wdata & s4_mask);
      else       s4_rdata <= mem4[s4_addr[5:0]];
    end
  end

  always @(posedge clock) begin
    if (rst0) begin
      for (int i = 0; i < 64; i++) mem0[i] <= {45'd0, 19'(32'h7FFC0 + i)};
      mem0[16] <= 64'h01234567_89ABCDEF;
    end else if (s0_ce) begin
      if (s0_we) mem0[s0_addr[5:0]] <= (mem0[s0_addr[5:0]] & ~s0_mask) | (s0_wdata & s0_mask);
      else       s0_rdata <= mem0[s0_addr[5:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic on_done(input string tag, input bit empty, input exp_t e,
                         input logic [63:0] rd, input logic [511:0] line);
    if (empty) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_done: got done=1 required done=0 (cycle %0d)", tag, cyc);
    end else begin
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      if (e.kind == 1) chk({tag, "_load_data"}, rd, e.rd);
      if (e.kind == 2) chk512({tag, "_line"}, line, e.line);
    end
  endtask

  // Monitors: every done pulse consumes the oldest expectation of its instance
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (done4 === 1'b1) begin
      if (q4.size() == 0) on_done("u4", 1'b1, e, rd4, line4);
      else begin e = q4.pop_front(); on_done("u4", 1'b0, e, rd4, line4); end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clock);
    if (done0 === 1'b1) begin
      if (q0.size() == 0) on_done("u0", 1'b1, e, rd0, line0);
      else begin e = q0.pop_front(); on_done("u0", 1'b0, e, rd0, line0); end
    end
  end

  task automatic wait_ready(input bit sel);
    int n = 0;
    while (((sel ? rdy0 : rdy4) !== 1'b1) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 required ready=1 within 60 cycles");
    end
  endtask

  // Presents one request at a negedge where ready=1 (cycle T); returns at the negedge of T+1
  task automatic issue(input bit sel, input logic [18:0] i_idx, input bit i_we, input bit i_bu,
                       input logic [63:0] i_mask, input logic [63:0] i_data, input int lat,
                       input int kind, input logic [63:0] erd, input logic [511:0] eline,
                       input bit push, output int t);
    exp_t e;
    wait_ready(sel);
    idx = i_idx; we = i_we; bu = i_bu; mask = i_mask; data = i_data;
    if (sel) ce0 = 1'b1; else ce4 = 1'b1;
    t = cyc;
    e.cyc = t + lat; e.kind = kind; e.rd = erd; e.line = eline;
    if (push) begin
      if (sel) q0.push_back(e); else q4.push_back(e);
    end
    @(negedge clock);
    ce0 = 1'b0;
    ce4 = 1'b0;
  endtask

  // Watches a LATENCY=4 burst from T+1 to its done cycle; optionally pokes chip_enable while busy
  task automatic burst_watch(input int t, input logic [18:0] base, input bit poke);
    int n = 0;
    int nwe = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clock);
      if (poke && (k == 3 || k == 9)) begin
        idx = 19'h10; we = 1'b1; bu = 1'b0; data = '0; ce4 = 1'b1;
      end else begin
        ce4 = 1'b0;
      end
      if (s4_we === 1'b1) nwe++;
      if (s4_ce === 1'b1) begin
        chk("burst_addr", 64'(s4_addr), 64'(base) + 64'(n));
        chk("burst_issue_cycle", 64'(cyc), 64'(t + 5 + n));
        n++;
      end
    end
    chk("burst_beat_count", 64'(n), 64'd8);
    chk("burst_no_write", 64'(nwe), 64'd0);
  endtask

  initial begin
    int t;
    int n;
    logic [511:0] el;
    logic [511:0] el_top;
    for (int k = 0; k < 8; k++) begin
      el[64*k +: 64]     = 64'(16 + k);
      el_top[64*k +: 64] = 64'(32'h7FFF8 + k);
    end
    rst4 = 1'b1; rst0 = 1'b1; ce4 = 1'b0; ce0 = 1'b0;
    idx = '0; we = 1'b0; bu = 1'b0; mask = '0; data = '0;

    repeat (3) @(negedge clock);
    chk("reset_ready4", 64'(rdy4), 64'd0);
    chk("reset_ready0", 64'(rdy0), 64'd0);
    chk("reset_sram_ce4", 64'(s4_ce), 64'd0);
    chk("reset_done4", 64'(done4), 64'd0);
    rst4 = 1'b0; rst0 = 1'b0;
    @(negedge clock);
    chk("ready4_after_reset", 64'(rdy4), 64'd1);
    chk("ready0_after_reset", 64'(rdy0), 64'd1);

    // Full-mask write at LATENCY=4: SRAM write at T+5, done T+6, ready back at T+7
    issue(1'b0, 19'h10, 1'b1, 1'b0, '1, 64'hDEADBEEF_00000000, 6, 0, '0, '0, 1'b1, t);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clock);
      chk("wr_sram_we", 64'(s4_we), (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) begin
        chk("wr_sram_addr", 64'(s4_addr), 64'h10);
        chk("wr_sram_wdata", s4_wdata, 64'hDEADBEEF_00000000);
      end
      if (k == 6) chk("wr_ready_during_done", 64'(rdy4), 64'd0);
      if (k == 7) chk("wr_ready_after_done", 64'(rdy4), 64'd1);
    end

    issue(1'b0, 19'h10, 1'b0, 1'b0, '1, '0, 7, 1, 64'hDEADBEEF_00000000, '0, 1'b1, t);
    issue(1'b0, 19'h10, 1'b1, 1'b0, '1, 64'h10, 6, 0, '0, '0, 1'b1, t);

    // Bursts from an unaligned index; the second has write_enable set and busy pokes
    issue(1'b0, 19'h13, 1'b0, 1'b1, '1, '0, 14, 2, '0, el, 1'b1, t);
    burst_watch(t, 19'h10, 1'b0);
    issue(1'b0, 19'h13, 1'b1, 1'b1, '1, 64'hFFFF0000_FFFF0000, 14, 2, '0, el, 1'b1, t);
    burst_watch(t, 19'h10, 1'b1);
    issue(1'b0, 19'h10, 1'b0, 1'b0, '1, '0, 7, 1, 64'h10, '0, 1'b1, t);
    issue(1'b0, 19'h13, 1'b0, 1'b0, '1, '0, 7, 1, 64'h13, '0, 1'b1, t);

    // Partial-mask write merges only the low half; a later write leaves both data outputs alone
    issue(1'b0, 19'h20, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 64'h11111111_22222222, 6, 0, '0, '0, 1'b1, t);
    repeat (4) @(negedge clock);
    chk("partial_sram_wmask", s4_mask, 64'h00000000_FFFFFFFF);
    chk("partial_sram_we", 64'(s4_we), 64'd1);
    issue(1'b0, 19'h20, 1'b0, 1'b0, '1, '0, 7, 1, 64'hAAAAAAAA_22222222, '0, 1'b1, t);
    issue(1'b0, 19'h21, 1'b1, 1'b0, '1, 64'h55555555_66666666, 6, 0, '0, '0, 1'b1, t);
    wait_ready(1'b0);
    chk("load_data_kept_over_write", rd4, 64'hAAAAAAAA_22222222);
    chk512("line_kept_over_write", line4, el);
    issue(1'b0, 19'h21, 1'b0, 1'b0, '1, '0, 7, 1, 64'h55555555_66666666, '0, 1'b1, t);

    // LATENCY=0: read, burst at the top of the space, then a burst aborted by reset at T+2
    issue(1'b1, 19'h10, 1'b0, 1'b0, '1, '0, 3, 1, 64'h01234567_89ABCDEF, '0, 1'b1, t);
    issue(1'b1, 19'h7FFFD, 1'b0, 1'b1, '1, '0, 10, 2, '0, el_top, 1'b1, t);
    issue(1'b1, 19'h13, 1'b0, 1'b1, '1, '0, 10, 2, '0, '0, 1'b0, t);
    @(negedge clock);
    chk("abort_sram_ce_before", 64'(s0_ce), 64'd1);
    rst0 = 1'b1;
    #1;
    chk("abort_sram_ce_now", 64'(s0_ce), 64'd0);
    chk("abort_ready_now", 64'(rdy0), 64'd0);
    repeat (2) @(negedge clock);
    rst0 = 1'b0;
    @(negedge clock);
    chk("abort_ready_after", 64'(rdy0), 64'd1);
    chk512("abort_line_reset", line0, '0);
    chk("abort_load_reset", rd0, 64'd0);
    issue(1'b1, 19'h10, 1'b0, 1'b0, '1, '0, 3, 1, 64'h01234567_89ABCDEF, '0, 1'b1, t);

    n = 0;
    while ((q4.size() != 0 || q0.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (q4.size() != 0 || q0.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_done: got %0d outstanding required 0", q4.size() + q0.size());
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
